// File: rtl/rst_seq.sv
// Reset synchroniser and sequencer: syncs RST_n release, stretches, then frees N_CH domains in order.
// Optional soft reset from RUN is compiled in when RST_SEQ_SOFT_RST_EN is defined.
module rst_seq #(
   parameter int STAGES  = 2,
   parameter int N_CH    = 3,
   parameter int STRETCH = 16,
   parameter int STAGGER = 8
) (
   input  logic            clk,
   input  logic            RST_n,
   input  logic            soft_rst_req,
   output logic [N_CH-1:0] rst_n,
   output logic            all_rdy
);
   localparam int MAXC = (STRETCH > STAGGER) ? STRETCH : STAGGER;
   localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
   localparam int HW   = $clog2(N_CH + 1);
   localparam logic [CW-1:0] STRETCH_C = CW'(STRETCH);
   localparam logic [CW-1:0] STAGGER_C = CW'(STAGGER);

   typedef enum logic [1:0] {S_HOLD, S_STRETCH, S_STAGGER, S_RUN} state_t;

   logic [STAGES-1:0] sync_q;
   logic              sync_n;
   logic              sync_hi;
   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [HW-1:0]     ch_q;
   logic [N_CH-1:0]   rst_q;
   logic              rdy_q;

   logic              soft_go;
   logic              start;
   logic              counting;
   logic              rel;
   logic              last;
   logic [HW-1:0]     rel_ch;
   logic [N_CH-1:0]   rel_mask;

   always_ff @(negedge clk or negedge RST_n) begin
      if (!RST_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], 1'b1};
      end
   end

   // Look one flop ahead so HOLD->STRETCH is taken on the same edge sync_n rises.
   assign sync_n  = sync_q[STAGES-1];
   assign sync_hi = sync_q[STAGES-2] | sync_n;

`ifdef RST_SEQ_SOFT_RST_EN
   assign soft_go = soft_rst_req && (state_q == S_RUN);
`else
   logic unused_soft;
   assign unused_soft = soft_rst_req;
   assign soft_go     = 1'b0;
`endif

   assign start    = ((state_q == S_HOLD) && sync_hi) || soft_go;
   assign counting = (state_q == S_STRETCH) || (state_q == S_STAGGER);
   assign rel      = (start && (STRETCH == 0)) || (counting && (cnt_q == CW'(1)));
   assign rel_ch   = start ? '0 : ch_q;
   assign last     = (STAGGER == 0) || (rel_ch == HW'(N_CH - 1));

   // Every channel up to and including the one being released is out of reset.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
         assign rel_mask[gi] = (HW'(gi) <= rel_ch);
      end
   endgenerate

   always_ff @(negedge clk or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= S_HOLD;
         cnt_q   <= '0;
         ch_q    <= '0;
         rst_q   <= '0;
         rdy_q   <= 1'b0;
      end else if (rel) begin
         if (last) begin
            state_q <= S_RUN;
            rst_q   <= '1;
            rdy_q   <= 1'b1;
            ch_q    <= HW'(N_CH);
         end else begin
            state_q <= S_STAGGER;
            rst_q   <= rel_mask;
            rdy_q   <= 1'b0;
            ch_q    <= rel_ch + HW'(1);
            cnt_q   <= STAGGER_C;
         end
      end else if (start) begin
         state_q <= S_STRETCH;
         rst_q   <= '0;
         rdy_q   <= 1'b0;
         ch_q    <= '0;
         cnt_q   <= STRETCH_C;
      end else if (counting) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign rst_n   = rst_q;
   assign all_rdy = rdy_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: default instance plus an all-zero-delay 4-channel instance.
module tb_rst_seq;
   logic       clk          = 1'b1;
   logic       RST_n        = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic [2:0] rst_a;
   logic       rdy_a;
   logic [3:0] rst_z;
   logic       rdy_z;

   always #5 clk = ~clk;

   rst_seq dut_a (
      .clk          (clk),
      .RST_n        (RST_n),
      .soft_rst_req (soft_rst_req),
      .rst_n        (rst_a),
      .all_rdy      (rdy_a)
   );

   rst_seq #(.STAGES(2), .N_CH(4), .STRETCH(0), .STAGGER(0)) dut_z (
      .clk          (clk),
      .RST_n        (RST_n),
      .soft_rst_req (soft_rst_req),
      .rst_n        (rst_z),
      .all_rdy      (rdy_z)
   );

   typedef struct {
      int         dut;
      logic [4:0] v;
      int         edge_no;
   } exp_t;

   exp_t exp_q[$];
   event push_ev;
   int   total  = 0;
   int   bad    = 0;
   int   edge_n = 0;

   task automatic step();
      @(negedge clk);
      edge_n++;
      #1;
   endtask

   // {all_rdy, rst_n[2:0]} for the default instance, with E0 = e0.
   function automatic logic [3:0] exp_a(input int n, input int e0);
      if (n < e0 + 16)      return 4'b0000;
      else if (n < e0 + 24) return 4'b0001;
      else if (n < e0 + 32) return 4'b0011;
      else                  return 4'b1111;
   endfunction

   task automatic push_a(input logic [3:0] v);
      exp_t e;
      e.dut = 0; e.v = {1'b0, v}; e.edge_no = edge_n;
      exp_q.push_back(e);
   endtask

   task automatic push_z(input logic [4:0] v);
      exp_t e;
      e.dut = 1; e.v = v; e.edge_no = edge_n;
      exp_q.push_back(e);
   endtask

   // Monitor: pops expectations and compares against the DUT outputs present now.
   initial begin
      exp_t       e;
      logic [4:0] got;
      forever begin
         @(push_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (e.dut == 0) ? {1'b0, rdy_a, rst_a} : {rdy_z, rst_z};
            total++;
            if (got !== e.v) begin
               bad++;
               $display("FAIL %s edge %0d: got {all_rdy,rst_n}=%b, want %b",
                        (e.dut == 0) ? "dut_a" : "dut_z", e.edge_no, got, e.v);
            end
         end
      end
   end

   initial begin
      // Reset state with clock running
      repeat (3) step();
      push_a(4'b0000); push_z(5'b00000); -> push_ev;
      $display("phase reset: checked");

      // Run 1: release mid-period, glitch RST_n after edge 30
      #4 RST_n = 1'b1;
      edge_n = 0;
      for (int n = 1; n <= 30; n++) begin
         step();
         push_a(exp_a(n, 2));
         push_z((n >= 2) ? 5'b11111 : 5'b00000);
         -> push_ev;
      end
      #2 RST_n = 1'b0;
      #1 push_a(4'b0000); push_z(5'b00000); -> push_ev;
      #1 RST_n = 1'b1;
      edge_n = 0;
      $display("phase run1+glitch: checked");

      // Run 2: full sequence after the glitch
      for (int n = 1; n <= 45; n++) begin
         step();
         push_a(exp_a(n, 2));
         push_z((n >= 2) ? 5'b11111 : 5'b00000);
         -> push_ev;
      end
      $display("phase run2: checked");

      // Long hold: RST_n low for 100 cycles
      #4 RST_n = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         step();
         push_a(4'b0000); push_z(5'b00000); -> push_ev;
      end
      $display("phase hold: checked");

      // Run 3: full sequence, soft requests at edges 40 and 60
      #4 RST_n = 1'b1;
      edge_n = 0;
      for (int n = 1; n <= 80; n++) begin
         soft_rst_req = (n == 40 || n == 60);
         step();
         soft_rst_req = 1'b0;
`ifdef RST_SEQ_SOFT_RST_EN
         push_a((n < 40) ? exp_a(n, 2) : exp_a(n, 40));
`else
         push_a(exp_a(n, 2));
`endif
         push_z((n >= 2) ? 5'b11111 : 5'b00000);
         -> push_ev;
      end
      $display("phase run3+soft: checked");

      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset synchroniser and sequencer for the Segway controller. It takes the raw asynchronous push-button/POR reset and synchronises its release through a configurable flop chain. It then holds reset for a programmable stretch period and releases N_CH downstream reset domains one after another, staggered by a fixed gap (e.g. inertial interface, balance controller, motor drive). It also reports when the whole sequence has completed.

## Interface
- STAGES, 2, synchroniser depth; legal range 2..4.
- N_CH, 3, number of sequenced reset outputs; legal range 1..8.
- STRETCH, 16, clk cycles between synchronised release and rst_n[0] release; 0 is legal.
- STAGGER, 8, clk cycles between release of rst_n[k] and rst_n[k+1]; 0 is legal.
- clk  input  1  system clock; all flops in this block are clocked on the falling edge of clk.
- RST_n  input  1  raw reset; asynchronous, active-low.
- soft_rst_req  input  1  synchronous soft-reset request, clk domain, active-high.
- rst_n  output  N_CH  sequenced active-low resets; bit 0 is released first.
- all_rdy  output  1  high once every rst_n bit is released.

## Operation
- Sync chain: STAGES flops.
  - All flops clear asynchronously when RST_n=0.
  - Otherwise they shift in 1'b1.
  - The chain output is `sync_n`.
- FSM: HOLD, STRETCH, STAGGER, RUN. A single down-counter is sized $clog2(max(STRETCH,STAGGER)+1), with a minimum width of 1. A channel index `ch` is sized $clog2(N_CH+1).
- RST_n=0: the FSM goes to HOLD asynchronously. The counter and `ch` clear. rst_n becomes all zeros and all_rdy=0.
- HOLD:
  - Remain while sync_n=0.
  - On the first edge with sync_n=1, go to STRETCH with counter=STRETCH.
- STRETCH:
  - Decrement the counter each edge.
  - At the edge where counter==0, set rst_n[0]=1 and ch=1.
  - Then go to STAGGER with counter=STAGGER, or to RUN if N_CH==1.
- STAGGER:
  - Decrement the counter each edge.
  - At the edge where counter==0, set rst_n[ch]=1 and increment ch.
  - Reload counter=STAGGER.
  - When ch reaches N_CH, go to RUN.
- RUN: rst_n is all ones and all_rdy=1; the FSM holds here.
- Once released, an rst_n bit is never reasserted except by RST_n or a soft reset.
- Zero-valued parameters: STRETCH=0 or STAGGER=0 means the corresponding release happens on the same edge as the preceding event. With STRETCH=0 and STAGGER=0, all channels and all_rdy release together on the sync_n-rise edge.

## Timing
- Reset values: rst_n all zeros; all_rdy=0; FSM in HOLD; sync chain all zeros.
- Assertion is asynchronous. rst_n and all_rdy fall within the RST_n-to-Q delay, with no clock needed.
- Release is synchronous to the falling edge of clk.
- Edge numbering: falling edge 1 is the first falling edge after RST_n rises, given setup is met. E0 is falling edge STAGES, where sync_n goes high and HOLD→STRETCH is taken.
- Release edges:
  - rst_n[0] rises at falling edge E0+STRETCH.
  - rst_n[k] rises at falling edge E0+STRETCH+k·STAGGER.
  - all_rdy rises on the same edge as rst_n[N_CH-1].
- RST_n low at any point, including a glitch shorter than one clk period, aborts the sequence immediately. The full sequence then restarts from edge 1 after RST_n rises again.
- Outputs are registered with no combinational path from inputs, except the asynchronous clear.

## Configuration
- Macro: RST_SEQ_SOFT_RST_EN.
- Defined:
  - soft_rst_req=1 sampled at a falling edge while in RUN clears rst_n and all_rdy at that edge.
  - The FSM enters STRETCH with counter=STRETCH; that edge acts as E0.
  - Requests in any state other than RUN are ignored.
- Undefined: the soft_rst_req port exists but is ignored, and no soft-reset logic is synthesised.

## Test plan
- Defaults (STAGES=2, N_CH=3, STRETCH=16, STAGGER=8), RST_n released mid-period → rst_n stays 3'b000 through edge 17, then:
  - rst_n[0]=1 at falling edge 18;
  - rst_n[1]=1 at edge 26;
  - rst_n[2]=1 and all_rdy=1 at edge 34.
- Defaults, RST_n pulsed low for 2 ns between edges at edge 30 → rst_n=3'b000 and all_rdy=0 immediately; after re-release, rst_n[0] rises 18 edges after release.
- Defaults, RST_n held low with clk running for 100 cycles → rst_n=3'b000 and all_rdy=0 throughout.
- STRETCH=0, STAGGER=0, N_CH=4 → rst_n=4'hF and all_rdy=1 together at falling edge 2.
- RST_SEQ_SOFT_RST_EN defined, defaults, soft_rst_req pulsed at edge 40:
  - rst_n=3'b000 at edge 40;
  - rst_n[0]=1 at edge 56; rst_n[2] and all_rdy=1 at edge 72.
  - A further request at edge 60 is ignored.
- RST_SEQ_SOFT_RST_EN undefined, same stimulus → rst_n stays 3'b111 and all_rdy stays 1.
